// File: rtl/tcam_ctrl.sv
// tcam_ctrl: arbitrates lookup and management access to the tcam array and tracks entry occupancy
package tcam_pkg;
    localparam int TCAM_W = 32;
    localparam int TCAM_D = 16;
    localparam int TCAM_AW = $clog2(TCAM_D);
    typedef logic [TCAM_W-1:0] cam_t;
    typedef logic [TCAM_AW-1:0] addr_t;
    typedef struct packed {
        addr_t addr;
        logic addr_vld;
        logic we;
        cam_t data;
        logic data_vld;
        cam_t mask;
    } tcam_req_t;
    typedef struct packed {
        logic addr_vld;
        addr_t addr;
        cam_t data;
    } tcam_resp_t;
endpackage

module tcam_ctrl
    import tcam_pkg::*;
#(
    parameter int KEY_WIDTH = 32,
    parameter int KEY_DEPTH = 16,
    parameter int CNT_W = $clog2(KEY_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lkp_valid,
    output logic                 lkp_ready,
    input  logic [KEY_WIDTH-1:0] lkp_key,
    input  logic [KEY_WIDTH-1:0] lkp_mask,
    output logic                 lkp_resp_vld,
    output logic                 lkp_hit,
    output addr_t                lkp_index,
    input  logic                 mgmt_valid,
    output logic                 mgmt_ready,
    input  logic [2:0]           mgmt_op,
    input  addr_t                mgmt_addr,
    input  logic [KEY_WIDTH-1:0] mgmt_data,
    output logic                 mgmt_done,
    output logic                 mgmt_err,
    output logic [KEY_WIDTH-1:0] mgmt_rdata,
    output logic                 mgmt_rvld,
    output addr_t                mgmt_raddr,
    output logic [CNT_W-1:0]     free_cnt,
    output logic                 full,
    output tcam_req_t            tcam_req,
    input  tcam_resp_t           tcam_resp
);
    localparam logic [2:0] OP_WRITE = 3'd0;
    localparam logic [2:0] OP_INSERT = 3'd1;
    localparam logic [2:0] OP_INVAL = 3'd2;
    localparam logic [2:0] OP_READ = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t               state;
    logic [KEY_DEPTH-1:0] bitmap;
    logic                 last_grant;
    addr_t                walk;
    addr_t                free_idx;
    addr_t                tgt;
    logic                 wr, inv, rd, err, clr_last;

    assign full = free_cnt == '0;
    assign lkp_ready = (state == IDLE) && lkp_valid && (!mgmt_valid || last_grant);
    assign mgmt_ready = (state == IDLE) && mgmt_valid && (!lkp_valid || !last_grant);
    assign clr_last = (state == CLEAR) && (walk == addr_t'(KEY_DEPTH - 1));

    // lowest free entry for INSERT
    always_comb begin
        free_idx = '0;
        for (int i = KEY_DEPTH - 1; i >= 0; i--)
            if (!bitmap[i]) free_idx = addr_t'(i);
    end

    // decode the granted management op (or the clear walk) into an array action
    always_comb begin
        tgt = mgmt_addr;
        wr = 1'b0;
        inv = 1'b0;
        rd = 1'b0;
        err = 1'b0;
        if (state == CLEAR) begin
            tgt = walk;
            inv = 1'b1;
        end else if (mgmt_ready) begin
            case (mgmt_op)
                OP_WRITE: wr = 1'b1;
                OP_INSERT: begin
                    tgt = free_idx;
                    wr = !full;
                    err = full;
                end
                OP_INVAL: inv = 1'b1;
                OP_READ: rd = 1'b1;
                OP_CLEAR: ;
                default: err = 1'b1;
            endcase
        end
    end

    // single request port to the array; idle fields stay zero
    always_comb begin
        tcam_req = '0;
        if (lkp_ready) begin
            tcam_req.data = lkp_key;
            tcam_req.mask = lkp_mask;
        end
        if (wr || inv || rd) begin
            tcam_req.addr = tgt;
            tcam_req.addr_vld = 1'b1;
            tcam_req.we = wr || inv;
            tcam_req.data = wr ? mgmt_data : '0;
            tcam_req.data_vld = wr;
        end
    end

    // state, occupancy shadow and registered responses
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            walk <= '0;
            bitmap <= '0;
            free_cnt <= CNT_W'(KEY_DEPTH);
            last_grant <= 1'b0;
            lkp_resp_vld <= 1'b0;
            lkp_hit <= 1'b0;
            lkp_index <= '0;
            mgmt_done <= 1'b0;
            mgmt_err <= 1'b0;
            mgmt_rdata <= '0;
            mgmt_rvld <= 1'b0;
            mgmt_raddr <= '0;
        end else begin
            if (lkp_ready && mgmt_valid) last_grant <= 1'b0;
            if (mgmt_ready && lkp_valid) last_grant <= 1'b1;
            if (wr) bitmap[tgt] <= 1'b1;
            if (inv) bitmap[tgt] <= 1'b0;
            free_cnt <= free_cnt - CNT_W'(wr && !bitmap[tgt]) + CNT_W'(inv && bitmap[tgt]);
            lkp_resp_vld <= lkp_ready;
            if (lkp_ready) begin
                lkp_hit <= tcam_resp.addr_vld;
                lkp_index <= tcam_resp.addr;
            end
            mgmt_done <= (mgmt_ready && mgmt_op != OP_CLEAR) || clr_last;
            mgmt_err <= err;
            if (mgmt_ready || clr_last) mgmt_raddr <= tgt;
            if (rd) begin
                mgmt_rdata <= tcam_resp.data;
                mgmt_rvld <= bitmap[tgt];
            end
            if (state == CLEAR) begin
                walk <= walk + 1'b1;
                if (clr_last) state <= IDLE;
            end else if (mgmt_ready && mgmt_op == OP_CLEAR) begin
                state <= CLEAR;
                walk <= '0;
            end
        end
    end
endmodule

// File: tb/tb_tcam_ctrl.sv
// tb_tcam_ctrl: random and directed checks of tcam_ctrl against a behavioural table model
module tb_tcam_ctrl;
    import tcam_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lkp_valid = 1'b0, lkp_ready;
    logic [31:0] lkp_key = '0, lkp_mask = '0;
    logic        lkp_resp_vld, lkp_hit;
    addr_t       lkp_index;
    logic        mgmt_valid = 1'b0, mgmt_ready;
    logic [2:0]  mgmt_op = '0;
    addr_t       mgmt_addr = '0;
    logic [31:0] mgmt_data = '0;
    logic        mgmt_done, mgmt_err, mgmt_rvld;
    logic [31:0] mgmt_rdata;
    addr_t       mgmt_raddr;
    logic [4:0]  free_cnt;
    logic        full;
    tcam_req_t   tcam_req;
    tcam_resp_t  tcam_resp;

    always #5 clk = ~clk;

    tcam_ctrl dut (
        .clk(clk), .rst(rst),
        .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_key(lkp_key), .lkp_mask(lkp_mask),
        .lkp_resp_vld(lkp_resp_vld), .lkp_hit(lkp_hit), .lkp_index(lkp_index),
        .mgmt_valid(mgmt_valid), .mgmt_ready(mgmt_ready), .mgmt_op(mgmt_op),
        .mgmt_addr(mgmt_addr), .mgmt_data(mgmt_data), .mgmt_done(mgmt_done),
        .mgmt_err(mgmt_err), .mgmt_rdata(mgmt_rdata), .mgmt_rvld(mgmt_rvld),
        .mgmt_raddr(mgmt_raddr), .free_cnt(free_cnt), .full(full),
        .tcam_req(tcam_req), .tcam_resp(tcam_resp)
    );

    // array emulation: combinational match/read, writes land on the clock edge
    cam_t        t_mem [16];
    logic [15:0] t_vld;
    always_comb begin
        tcam_resp = '0;
        tcam_resp.data = t_mem[tcam_req.addr];
        for (int i = 15; i >= 0; i--)
            if (t_vld[i] && ((t_mem[i] ^ tcam_req.data) & tcam_req.mask) == '0) begin
                tcam_resp.addr_vld = 1'b1;
                tcam_resp.addr = addr_t'(i);
            end
    end
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) t_mem[i] <= '0;
            t_vld <= '0;
        end else if (tcam_req.addr_vld && tcam_req.we) begin
            t_mem[tcam_req.addr] <= tcam_req.data;
            t_vld[tcam_req.addr] <= tcam_req.data_vld;
        end
    end

    int n_chk = 0, n_pass = 0;
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // behavioural model: table of entries, who was granted last, and clear progress
    bit [31:0] m_key [16];
    bit        m_vld [16];
    bit        m_last, m_clear, chk_en = 1'b0;
    int        m_walk;
    bit        e_lv, e_hit, e_done, e_err, e_chk_ra, e_chk_rd, e_rvld;
    int        e_idx, e_raddr;
    bit [31:0] e_rdata;

    function automatic int m_free();
        int n = 16;
        for (int i = 0; i < 16; i++) n -= int'(m_vld[i]);
        return n;
    endfunction

    function automatic void m_write(int a, bit [31:0] d);
        m_key[a] = d;
        m_vld[a] = 1'b1;
        e_raddr = a;
        e_chk_ra = 1'b1;
    endfunction

    always @(posedge clk) begin
        bit lg, mg;
        int a, f;
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_key[i] = '0;
                m_vld[i] = 1'b0;
            end
            {m_last, m_clear, e_lv, e_done, e_err, e_chk_ra, e_chk_rd} = '0;
            m_walk = 0;
        end else begin
            lg = !m_clear && lkp_valid && (!mgmt_valid || m_last);
            mg = !m_clear && mgmt_valid && (!lkp_valid || !m_last);
            {e_lv, e_done, e_err, e_chk_ra, e_chk_rd} = '0;
            if (m_clear) begin
                m_key[m_walk] = '0;
                m_vld[m_walk] = 1'b0;
                if (m_walk == 15) begin
                    m_clear = 1'b0;
                    e_done = 1'b1;
                end
                m_walk++;
            end
            if (lg) begin
                e_lv = 1'b1;
                e_hit = 1'b0;
                for (int i = 15; i >= 0; i--)
                    if (m_vld[i] && ((m_key[i] ^ lkp_key) & lkp_mask) == 0) begin
                        e_hit = 1'b1;
                        e_idx = i;
                    end
                if (mgmt_valid) m_last = 1'b0;
            end
            if (mg) begin
                if (lkp_valid) m_last = 1'b1;
                a = int'(mgmt_addr);
                e_done = 1'b1;
                case (mgmt_op)
                    3'd0: m_write(a, mgmt_data);
                    3'd1: begin
                        f = -1;
                        for (int i = 15; i >= 0; i--) if (!m_vld[i]) f = i;
                        if (f < 0) e_err = 1'b1;
                        else m_write(f, mgmt_data);
                    end
                    3'd2: begin
                        m_key[a] = '0;
                        m_vld[a] = 1'b0;
                        e_raddr = a;
                        e_chk_ra = 1'b1;
                    end
                    3'd3: begin
                        e_rdata = m_key[a];
                        e_rvld = m_vld[a];
                        e_chk_rd = 1'b1;
                        e_raddr = a;
                        e_chk_ra = 1'b1;
                    end
                    3'd4: begin
                        e_done = 1'b0;
                        m_clear = 1'b1;
                        m_walk = 0;
                    end
                    default: e_err = 1'b1;
                endcase
            end
        end
    end

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("lkp_ready", lkp_ready, !m_clear && lkp_valid && (!mgmt_valid || m_last));
            check("mgmt_ready", mgmt_ready, !m_clear && mgmt_valid && (!lkp_valid || !m_last));
            check("free_cnt", free_cnt, m_free());
            check("full", full, m_free() == 0);
            check("lkp_resp_vld", lkp_resp_vld, e_lv);
            if (e_lv) begin
                check("lkp_hit", lkp_hit, e_hit);
                if (e_hit) check("lkp_index", lkp_index, e_idx);
            end
            check("mgmt_done", mgmt_done, e_done);
            if (e_done) check("mgmt_err", mgmt_err, e_err);
            if (e_done && e_chk_ra) check("mgmt_raddr", mgmt_raddr, e_raddr);
            if (e_done && e_chk_rd) begin
                check("mgmt_rdata", mgmt_rdata, e_rdata);
                check("mgmt_rvld", mgmt_rvld, e_rvld);
            end
        end
    end

    logic        r_done, r_err, r_rvld, r_we, r_av, r_hit;
    logic [31:0] r_rdata;
    int          r_raddr, r_idx;

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: no handshake within bound at %0t", nm, $time);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_mgmt(input logic [2:0] op, input int a, input logic [31:0] d);
        int n = 0;
        @(posedge clk);
        #1;
        mgmt_valid = 1'b1;
        mgmt_op = op;
        mgmt_addr = addr_t'(a);
        mgmt_data = d;
        @(negedge clk);
        while (!mgmt_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mgmt_ready) timeout("mgmt_accept");
        r_we = tcam_req.we;
        r_av = tcam_req.addr_vld;
        @(posedge clk);
        #1 mgmt_valid = 1'b0;
        @(negedge clk);
        r_done = mgmt_done;
        r_err = mgmt_err;
        r_raddr = int'(mgmt_raddr);
        r_rdata = mgmt_rdata;
        r_rvld = mgmt_rvld;
    endtask

    task automatic do_lkp(input logic [31:0] k, input logic [31:0] m);
        int n = 0;
        @(posedge clk);
        #1;
        lkp_valid = 1'b1;
        lkp_key = k;
        lkp_mask = m;
        @(negedge clk);
        while (!lkp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!lkp_ready) timeout("lkp_accept");
        @(posedge clk);
        #1 lkp_valid = 1'b0;
        @(negedge clk);
        r_hit = lkp_hit;
        r_idx = int'(lkp_index);
        check("lkp_resp_pulse", lkp_resp_vld, 1'b1);
    endtask

    initial begin
        int cnt, n, f;
        bit seen;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_free_cnt", free_cnt, 16);
        check("rst_full", full, 0);
        check("rst_resp", {lkp_resp_vld, mgmt_done}, 0);

        do_mgmt(3'd0, 3, 32'hDEAD_BEEF);
        check("write3_done", {r_done, r_err}, 2'b10);
        check("write3_raddr", r_raddr, 3);
        do_lkp(32'hDEAD_BEEF, 32'hFFFF_FFFF);
        check("basic_hit", r_hit, 1);
        check("basic_idx", r_idx, 3);
        check("basic_free", free_cnt, 15);

        do_mgmt(3'd0, 2, 32'h1234_0000);
        do_mgmt(3'd0, 5, 32'h1234_FFFF);
        do_lkp(32'h1234_5678, 32'hFFFF_0000);
        check("mask_hit", r_hit, 1);
        check("mask_idx", r_idx, 2);
        do_mgmt(3'd2, 2, 32'h0);
        do_lkp(32'h1234_5678, 32'hFFFF_0000);
        check("mask_idx_after_inv", r_idx, 5);
        check("mask_free", free_cnt, 14);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_mgmt(3'd1, 0, 32'hA000_0000 + i);
            check("insert_raddr", r_raddr, i);
            check("insert_err", r_err, 0);
        end
        check("insert_full", full, 1);
        do_mgmt(3'd1, 0, 32'h5555_5555);
        check("insert17_err", {r_done, r_err}, 2'b11);
        check("insert17_free", free_cnt, 0);
        do_mgmt(3'd3, 7, 32'h0);
        check("read7_data", r_rdata, 32'hA000_0007);
        check("read7_rvld", r_rvld, 1);

        @(posedge clk);
        #1;
        mgmt_valid = 1'b1;
        mgmt_op = 3'd3;
        mgmt_addr = 4'd7;
        lkp_valid = 1'b1;
        lkp_key = 32'hA000_0003;
        lkp_mask = 32'hFFFF_FFFF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("contend_one_ready", {mgmt_ready, lkp_ready}, (c % 2 == 0) ? 2'b10 : 2'b01);
        end
        @(posedge clk);
        #1 {mgmt_valid, lkp_valid} = 2'b00;

        do_reset();
        for (int i = 0; i < 8; i++) do_mgmt(3'd0, i, 32'hB000_0000 + i);
        @(posedge clk);
        #1;
        mgmt_valid = 1'b1;
        mgmt_op = 3'd4;
        @(negedge clk);
        check("clear_accept", mgmt_ready, 1);
        @(posedge clk);
        #1;
        mgmt_op = 3'd3;
        mgmt_addr = '0;
        lkp_valid = 1'b1;
        lkp_key = 32'hB000_0001;
        lkp_mask = 32'hFFFF_FFFF;
        cnt = 0;
        n = 0;
        @(negedge clk);
        while (!mgmt_done && n < 40) begin
            if (!lkp_ready && !mgmt_ready) cnt++;
            n++;
            @(negedge clk);
        end
        if (!mgmt_done) timeout("clear_done");
        check("clear_busy_cycles", cnt, 16);
        check("clear_err", mgmt_err, 0);
        check("clear_free", free_cnt, 16);
        #2 {mgmt_valid, lkp_valid} = 2'b00;
        for (int i = 0; i < 8; i++) begin
            do_lkp(32'hB000_0000 + i, 32'hFFFF_FFFF);
            check("clear_miss", r_hit, 0);
        end

        for (int i = 0; i < 4; i++) do_mgmt(3'd0, i, 32'hD000_0000 + i);
        @(posedge clk);
        #1;
        mgmt_valid = 1'b1;
        mgmt_op = 3'd4;
        @(posedge clk);
        #1 mgmt_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstclr_free", free_cnt, 16);
        seen = mgmt_done;
        repeat (20) begin
            @(negedge clk);
            seen |= mgmt_done;
        end
        check("rstclr_no_done", seen, 0);
        do_lkp(32'hD000_0001, 32'hFFFF_FFFF);
        check("rstclr_miss", r_hit, 0);

        do_mgmt(3'd0, 1, 32'hC000_0001);
        f = int'(free_cnt);
        do_mgmt(3'd7, 1, 32'hFFFF_FFFF);
        check("illegal_done_err", {r_done, r_err}, 2'b11);
        check("illegal_no_access", {r_we, r_av}, 2'b00);
        check("illegal_free", free_cnt, f);
        do_mgmt(3'd3, 1, 32'h0);
        check("illegal_untouched", r_rdata, 32'hC000_0001);

        for (int c = 0; c < 3000; c++) begin
            int r;
            @(posedge clk);
            #1;
            rst = $urandom_range(0, 499) == 0;
            lkp_valid = $urandom_range(0, 1) == 1;
            mgmt_valid = $urandom_range(0, 1) == 1;
            lkp_key = 32'hC0DE_0000 | 32'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: lkp_mask = 32'hFFFF_FFFF;
                1: lkp_mask = 32'hFFFF_FFFC;
                2: lkp_mask = 32'hFFFF_FFF8;
                default: lkp_mask = 32'h0;
            endcase
            mgmt_addr = addr_t'($urandom_range(0, 15));
            mgmt_data = 32'hC0DE_0000 | 32'($urandom_range(0, 7));
            r = $urandom_range(0, 99);
            mgmt_op = r < 30 ? 3'd0 : r < 50 ? 3'd1 : r < 70 ? 3'd2 : r < 92 ? 3'd3 :
                      r < 95 ? 3'd4 : 3'($urandom_range(5, 7));
        end
        @(posedge clk);
        #1 {rst, lkp_valid, mgmt_valid} = 3'b000;
        repeat (25) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tcam_ctrl.md
# tcam_ctrl

Sequencing and arbitration front-end for the `tcam` array. It shares the single TCAM request port between a lookup requester and a management requester, one access per cycle. It keeps a shadow valid bitmap of every entry so it can report occupancy and allocate the lowest free entry. It also runs a multi-cycle CLEAR walk over the whole array. It sits between the match pipeline and control software on one side, and `tcam` on the other.

## Interface
- `KEY_WIDTH`, 32, entry/key width; must equal the `cam_t` width.
- `KEY_DEPTH`, 16, number of TCAM entries; must match the attached `tcam`.
- `CNT_W`, `$clog2(KEY_DEPTH+1)`, derived width of the occupancy counter.

Ports (name, direction, width, meaning):
- `clk` in 1 — single clock; all logic is on its rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `lkp_valid` in 1, `lkp_ready` out 1 — lookup request handshake.
- `lkp_key` in `cam_t` — lookup key.
- `lkp_mask` in `cam_t` — compare mask; 1 = bit compared.
- `lkp_resp_vld` out 1 — one-cycle pulse carrying the lookup result.
- `lkp_hit` out 1 — lookup matched an entry.
- `lkp_index` out `addr_t` — lowest matching index.
- `mgmt_valid` in 1, `mgmt_ready` out 1 — management request handshake.
- `mgmt_op` in 3 — 000 WRITE, 001 INSERT, 010 INVALIDATE, 011 READ, 100 CLEAR; other codes are illegal.
- `mgmt_addr` in `addr_t` — target entry for WRITE, INVALIDATE and READ.
- `mgmt_data` in `cam_t` — entry data for WRITE and INSERT.
- `mgmt_done` out 1 — one-cycle completion pulse.
- `mgmt_err` out 1 — qualified by `mgmt_done`.
- `mgmt_rdata` out `cam_t` — read data.
- `mgmt_rvld` out 1 — entry valid bit returned by READ.
- `mgmt_raddr` out `addr_t` — address the operation acted on.
- `free_cnt` out `CNT_W` — number of invalid entries.
- `full` out 1 — `free_cnt == 0`.
- `tcam_req` out `tcam_req_t` — request to the array.
- `tcam_resp` in `tcam_resp_t` — response from the array.

## Operation
- **FSM states:** IDLE, CLEAR.
- **Reset:** state IDLE; bitmap all 0; `free_cnt = KEY_DEPTH`; `full = 0`; `last_grant = 0` (lookup); all response outputs 0.
- **Default `tcam_req`:** all fields 0. With this default no write and no read occurs, but the match logic still evaluates the data/mask fields.

**Arbitration in IDLE (one grant per cycle):**
- Only one requester valid: that requester is granted.
- Both valid: the requester not granted last time wins. `last_grant` updates only when both are valid.
- `lkp_ready` and `mgmt_ready` are combinational from the valids, state and `last_grant`. At most one ready is high per cycle.
- In CLEAR, both readies are 0.

**Lookup grant:**
- Drive `tcam_req.data = lkp_key`, `mask = lkp_mask`, `addr_vld = 0`.
- Register `tcam_resp.addr_vld` into `lkp_hit` and `tcam_resp.addr` into `lkp_index`.
- The entry valid bit is checked inside the array, so invalid entries never hit.

**Management grant (all ops except CLEAR):**
- **WRITE:** drive `addr = mgmt_addr`, `addr_vld = 1`, `we = 1`, `data = mgmt_data`, `data_vld = 1`. Set the bitmap bit. `free_cnt` decrements only if the bit was previously 0.
- **INSERT:** the target is the lowest 0 bit in the bitmap, found by a priority encoder. If `full`, there is no array access and `mgmt_err = 1`. Otherwise perform a WRITE to that index; `mgmt_raddr` returns the index.
- **INVALIDATE:** write `data = '0`, `data_vld = 0`. Clear the bitmap bit. `free_cnt` increments only if the bit was previously 1.
- **READ:** drive `addr_vld = 1`, `we = 0`. Register `tcam_resp.data` into `mgmt_rdata` and the bitmap bit into `mgmt_rvld`.
- **Illegal op:** no array access; `mgmt_err = 1`.

**CLEAR (handshake accepted in IDLE):**
- Go to CLEAR with walk counter 0.
- Each CLEAR cycle invalidates the entry at the counter (as INVALIDATE) and increments the counter.
- After entry `KEY_DEPTH-1`: bitmap = 0, `free_cnt = KEY_DEPTH`, return to IDLE, pulse `mgmt_done` with `mgmt_err = 0`.

**`free_cnt` invariant:** always equals `KEY_DEPTH` minus popcount(bitmap). It never wraps; WRITE to an already-valid entry and INVALIDATE of an already-invalid entry leave it unchanged.

## Timing
- **Lookup latency:** `lkp_resp_vld` pulses exactly 1 cycle after the accepting edge. A result is produced for every accepted lookup, with no backpressure.
- **Management latency:** `mgmt_done` pulses 1 cycle after accept for WRITE, INSERT, INVALIDATE, READ and illegal ops. CLEAR takes `KEY_DEPTH` CLEAR cycles; `mgmt_done` pulses 1 cycle after the last of them.
- **Visibility:** a write or invalidate is visible to a lookup accepted in the next cycle. `free_cnt` and `full` update on the accepting edge.
- **Back-to-back:** a new request may be accepted every cycle in IDLE, including the cycle in which the previous response pulses.
- **Sustained contention:** with both requesters continuously valid, grants strictly alternate.
- **Reset mid-CLEAR:** return to IDLE with reset values. No `mgmt_done` pulse; pending response pulses are dropped.

## Test plan
- **Basic lookup:** WRITE addr 3 = 0xDEAD_BEEF, then lookup key 0xDEAD_BEEF, mask all-ones → `lkp_hit = 1`, `lkp_index = 3`, `free_cnt = 15`.
- **Masked match and priority:** WRITE 2 = 0x1234_0000 and WRITE 5 = 0x1234_FFFF, then lookup key 0x1234_5678 with mask 0xFFFF_0000 → hit, index 2. After INVALIDATE 2, the same lookup → index 5.
- **INSERT until full:** INSERT 16 times → `mgmt_raddr` 0..15 in order, then `full = 1`. A 17th INSERT → `mgmt_err = 1`, `free_cnt` stays 0.
- **Contention:** hold `lkp_valid` and `mgmt_valid` (READ) for 6 cycles → grants alternate mgmt/lkp per `last_grant`. The READ of a valid entry returns its data with `mgmt_rvld = 1`.
- **CLEAR:** after populating 8 entries, issue CLEAR → both readies are 0 for 16 cycles, then `mgmt_done` pulses, `free_cnt = 16`, and every lookup misses.
- **Reset and illegal op:** assert `rst` at CLEAR cycle 5 → the next cycle is IDLE with `free_cnt = 16` and no `mgmt_done`. Op 111 → `mgmt_done` with `mgmt_err = 1` and no array write.
